// File: rtl/banked_sync_fifo.sv
// banked_sync_fifo: single-clock first-word-fall-through FIFO over a banked
// block-RAM array. Upper pointer bits pick the bank and lower bits the word.
// A one-word RAM output stage sits between the banks and the read_data
// register, which sustains one pop per cycle.
//
// Handshake: a write is taken on a rising edge when write_enable && !full.
// A pop is taken when read_enable && read_valid, and read_data is the word
// consumed. A dropped write pulses overflow and an ignored pop pulses
// underflow, each for one cycle after the offending edge.
module banked_sync_fifo #(
    parameter int DATA_WIDTH         = 9,
    parameter int BANK_DEPTH         = 2048,
    parameter int BANK_COUNT         = 4,
    parameter int ALMOST_FULL_LEVEL  = 8064,
    parameter int ALMOST_EMPTY_LEVEL = 16,
    localparam int DEPTH      = BANK_DEPTH * BANK_COUNT,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int BANK_BITS = $clog2(BANK_COUNT);
    localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int IN_BITS   = $clog2(BANK_DEPTH);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_LVL   = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_LVL   = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem    [BANK_COUNT][BANK_DEPTH];
    logic [DATA_WIDTH-1:0] bank_q [BANK_COUNT];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_count;    // written words not yet read out of RAM
    logic                  stage_valid;  // bank output register holds an unforwarded word
    logic [SEL_W-1:0]      rd_bank_q;    // bank that produced the staged word

    logic [SEL_W-1:0]   wr_bank;
    logic [SEL_W-1:0]   rd_bank;
    logic [IN_BITS-1:0] wr_addr;
    logic [IN_BITS-1:0] rd_addr;
    logic               wr_accept;
    logic               pop;
    logic               stage_move;
    logic               issue;

    assign wr_bank = SEL_W'(wr_ptr >> IN_BITS);
    assign rd_bank = SEL_W'(rd_ptr >> IN_BITS);
    assign wr_addr = wr_ptr[IN_BITS-1:0];
    assign rd_addr = rd_ptr[IN_BITS-1:0];

    assign full         = (fill_count == CNT_FULL);
    assign empty        = (fill_count == '0);
    assign almost_full  = (fill_count >= AF_LVL);
    assign almost_empty = (fill_count <= AE_LVL);

    // Acceptance and prefetch decisions. A RAM read is issued only when the
    // staged word is absent or leaving this cycle, so nothing is overwritten.
    always_comb begin
        wr_accept  = write_enable && !full;
        pop        = read_enable && read_valid;
        stage_move = stage_valid && (!read_valid || pop);
        issue      = (ram_count != '0) && (!stage_valid || stage_move);
    end

    // Bank storage: only the addressed bank is written or read.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wr_bank][wr_addr] <= write_data;
        end
        if (issue) begin
            bank_q[rd_bank] <= mem[rd_bank][rd_addr];
        end
    end

    // Pointers, counters, output stage and error pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_count   <= '0;
            fill_count  <= '0;
            stage_valid <= 1'b0;
            rd_bank_q   <= '0;
            read_data   <= '0;
            read_valid  <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                rd_bank_q <= rd_bank;
            end

            case ({wr_accept, issue})
                2'b10:   ram_count <= ram_count + CNT_ONE;
                2'b01:   ram_count <= ram_count - CNT_ONE;
                default: ram_count <= ram_count;
            endcase

            case ({wr_accept, pop})
                2'b10:   fill_count <= fill_count + CNT_ONE;
                2'b01:   fill_count <= fill_count - CNT_ONE;
                default: fill_count <= fill_count;
            endcase

            if (issue) begin
                stage_valid <= 1'b1;
            end else if (stage_move) begin
                stage_valid <= 1'b0;
            end

            if (stage_move) begin
                read_data  <= bank_q[rd_bank_q];
                read_valid <= 1'b1;
            end else if (pop) begin
                read_valid <= 1'b0;
            end

            overflow  <= write_enable && full;
            underflow <= read_enable && !read_valid;
        end
    end

endmodule

// File: tb/tb_banked_sync_fifo.sv
// Bench for banked_sync_fifo: directed steps with a scoreboard queue of
// expected words, checked at every pop.
module tb_banked_sync_fifo;

    localparam int W     = 9;
    localparam int DEPTH = 8192;
    localparam int AW    = 13;

    logic          clock;
    logic          reset;
    logic          write_enable;
    logic [W-1:0]  write_data;
    logic          read_enable;
    logic [W-1:0]  read_data;
    logic          read_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   fill_count;
    logic          overflow;
    logic          underflow;

    logic [W-1:0] exp_q[$];
    int           model_count;
    int           n_checks;
    int           n_fail;

    banked_sync_fifo dut (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill_count   (fill_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from just after an edge; pops are scored against the
    // queue before the edge, accepted writes are queued.
    task automatic do_cycle(input logic we, input logic [W-1:0] wd, input logic re);
        logic wr_acc;
        logic pop_acc;
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        wr_acc  = we && (model_count != DEPTH);
        pop_acc = re && read_valid;
        if (pop_acc) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'd1, 32'd0);
            end else begin
                check("pop_data", 32'(read_data), 32'(exp_q.pop_front()));
            end
        end
        if (wr_acc) exp_q.push_back(wd);
        model_count = model_count + (wr_acc ? 1 : 0) - (pop_acc ? 1 : 0);
        @(posedge clock);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        model_count  = 0;
        reset        = 1'b1;
        write_enable = 1'b0;
        write_data   = '0;
        read_enable  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_read_valid", 32'(read_valid), 32'd0);
        check("rst_read_data", 32'(read_data), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_fill", 32'(fill_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);

        // First word latency: write at E0, visible after E2
        do_cycle(1'b1, 9'h1A5, 1'b0);
        check("lat_rv_e0", 32'(read_valid), 32'd0);
        do_cycle(1'b0, '0, 1'b0);
        check("lat_rv_e1", 32'(read_valid), 32'd0);
        do_cycle(1'b0, '0, 1'b0);
        check("lat_rv_e2", 32'(read_valid), 32'd1);
        check("lat_data_e2", 32'(read_data), 32'h1A5);
        check("lat_fill", 32'(fill_count), 32'd1);
        check("lat_empty", 32'(empty), 32'd0);
        check("lat_almost_empty", 32'(almost_empty), 32'd1);
        do_cycle(1'b0, '0, 1'b1);
        check("lat_rv_after_pop", 32'(read_valid), 32'd0);
        check("lat_empty_after_pop", 32'(empty), 32'd1);

        // Ignored pop on an empty FIFO
        do_cycle(1'b0, '0, 1'b1);
        check("unf_pulse", 32'(underflow), 32'd1);
        check("unf_fill", 32'(fill_count), 32'd0);
        do_cycle(1'b0, '0, 1'b0);
        check("unf_clear", 32'(underflow), 32'd0);

        // Fill to capacity, checking thresholds
        for (int i = 0; i < DEPTH; i++) begin
            int k;
            do_cycle(1'b1, 9'(i), 1'b0);
            k = i + 1;
            if (k == 16 || k == 17 || k == 8063 || k == 8064 || k == 8191 || k == DEPTH) begin
                check("fill_count", 32'(fill_count), 32'(k));
                check("fill_almost_full", 32'(almost_full), (k >= 8064) ? 32'd1 : 32'd0);
                check("fill_almost_empty", 32'(almost_empty), (k <= 16) ? 32'd1 : 32'd0);
                check("fill_full", 32'(full), (k == DEPTH) ? 32'd1 : 32'd0);
            end
        end
        check("full_rv", 32'(read_valid), 32'd1);

        // Write while full is dropped
        do_cycle(1'b1, 9'h055, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_fill", 32'(fill_count), 32'(DEPTH));
        do_cycle(1'b0, '0, 1'b0);
        check("ovf_clear", 32'(overflow), 32'd0);
        check("ovf_fill_hold", 32'(fill_count), 32'(DEPTH));

        // Write and pop together while full: pop taken, write dropped
        do_cycle(1'b1, 9'h0AA, 1'b1);
        check("wp_full_overflow", 32'(overflow), 32'd1);
        check("wp_full_fill", 32'(fill_count), 32'(DEPTH - 1));
        check("wp_full_flag", 32'(full), 32'd0);

        // Drain the rest with read_enable held: no bubbles
        for (int n = 0; n < DEPTH - 1; n++) begin
            check("drain_rv", 32'(read_valid), 32'd1);
            do_cycle(1'b0, '0, 1'b1);
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_rv_end", 32'(read_valid), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);

        // 2050 words across the bank0 -> bank1 boundary
        for (int i = 0; i < 2050; i++) begin
            do_cycle(1'b1, 9'(i), 1'b0);
        end
        check("b2050_fill", 32'(fill_count), 32'd2050);
        for (int n = 0; n < 2050; n++) begin
            check("b2050_rv", 32'(read_valid), 32'd1);
            do_cycle(1'b0, '0, 1'b1);
        end
        check("b2050_left", 32'(exp_q.size()), 32'd0);
        check("b2050_rv_end", 32'(read_valid), 32'd0);
        check("b2050_empty", 32'(empty), 32'd1);

        // Steady stream, write and read every cycle: both pointers wrap twice
        for (int n = 0; n < 20000; n++) begin
            do_cycle(1'b1, 9'($urandom_range(0, 511)), 1'b1);
            if (n >= 2 && (n % 500 == 2)) begin
                check("stream_fill", 32'(fill_count), 32'd3);
                check("stream_rv", 32'(read_valid), 32'd1);
            end
        end
        for (int n = 0; n < 10; n++) begin
            if (exp_q.size() > 0) do_cycle(1'b0, '0, 1'b1);
        end
        check("stream_left", 32'(exp_q.size()), 32'd0);
        check("stream_empty", 32'(empty), 32'd1);

        // Asynchronous reset with 100 words held
        for (int i = 0; i < 100; i++) begin
            do_cycle(1'b1, 9'(i + 100), 1'b0);
        end
        check("prerst_fill", 32'(fill_count), 32'd100);
        #3;
        reset = 1'b1;
        #1;
        check("arst_fill", 32'(fill_count), 32'd0);
        check("arst_rv", 32'(read_valid), 32'd0);
        check("arst_data", 32'(read_data), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_full", 32'(full), 32'd0);
        check("arst_almost_empty", 32'(almost_empty), 32'd1);
        check("arst_almost_full", 32'(almost_full), 32'd0);
        #2;
        reset = 1'b0;
        exp_q.delete();
        model_count = 0;
        @(posedge clock);
        #1;
        do_cycle(1'b1, 9'h0C3, 1'b0);
        for (int n = 0; n < 5; n++) begin
            if (!read_valid) do_cycle(1'b0, '0, 1'b0);
        end
        check("post_rst_rv", 32'(read_valid), 32'd1);
        check("post_rst_data", 32'(read_data), 32'h0C3);
        do_cycle(1'b0, '0, 1'b1);
        check("post_rst_left", 32'(exp_q.size()), 32'd0);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
